// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction memory
// and holds the fetched word for the control path until it is consumed.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] MEM_LIMIT = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_inc,
   input  logic        pc_load,
   input  logic [31:0] pc_target,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   input  logic        mem_fault,
   output logic [31:0] instruction,
   output logic        wait_instr,
   output logic        instr_segv,
   output logic [31:0] pc
);

   typedef enum logic [1:0] {
      RESET_HOLD = 2'd0,
      FETCH      = 2'd1,
      VALID      = 2'd2,
      FAULT      = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        segv_q, segv_d;
   logic        addr_ok;

   assign addr_ok = (pc_q[1:0] == 2'b00) && (pc_q < MEM_LIMIT);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      mem_req = 1'b0;

      unique case (state_q)
         RESET_HOLD: state_d = FETCH;

         FETCH: begin
            mem_req = addr_ok;
            if (pc_load) begin
               // Redirect abandons the read; RESET_HOLD doubles as the one-cycle request gap.
               pc_d    = pc_target;
               state_d = RESET_HOLD;
            end else if (!addr_ok || mem_fault) begin
               state_d = FAULT;
            end else if (mem_ready) begin
               instr_d = mem_rdata;
               state_d = VALID;
            end
         end

         VALID: begin
            if (pc_load) begin
               pc_d    = pc_target;
               state_d = FETCH;
            end else if (pc_inc) begin
               pc_d    = pc_q + 32'd4;
               state_d = FETCH;
            end
         end

         FAULT: begin
            if (pc_load) begin
               pc_d    = pc_target;
               state_d = FETCH;
            end
         end

         default: state_d = RESET_HOLD;
      endcase

      segv_d = (state_d == FAULT);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RESET_HOLD;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0000_0000;
         segv_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         segv_q  <= segv_d;
      end
   end

   assign mem_addr    = pc_q;
   assign pc          = pc_q;
   assign instruction = instr_q;
   assign wait_instr  = (state_q != VALID);
   assign instr_segv  = segv_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a flag-based behavioural model.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] LIMIT  = 32'h0001_0000;

   logic        clk;
   logic        reset;
   logic        pc_inc;
   logic        pc_load;
   logic [31:0] pc_target;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        mem_fault;
   logic [31:0] instruction;
   logic        wait_instr;
   logic        instr_segv;
   logic [31:0] pc;

   int n_checks = 0;
   int n_errors = 0;

   instr_fetch #(
      .RESET_PC (RST_PC),
      .MEM_LIMIT(LIMIT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_inc     (pc_inc),
      .pc_load    (pc_load),
      .pc_target  (pc_target),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .mem_fault  (mem_fault),
      .instruction(instruction),
      .wait_instr (wait_instr),
      .instr_segv (instr_segv),
      .pc         (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the block either holds a word, is faulted, is in a
   // no-request gap (after reset or a mid-fetch redirect), or is fetching.
   logic        m_init = 1'b0;
   logic        m_have, m_fault, m_gap;
   logic [31:0] m_pc, m_instr;

   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= LIMIT);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_init  <= 1'b1;
         m_pc    <= RST_PC;
         m_instr <= 32'h0;
         m_have  <= 1'b0;
         m_fault <= 1'b0;
         m_gap   <= 1'b1;
      end else if (m_init) begin
         if (m_gap) begin
            m_gap <= 1'b0;
         end else if (m_fault) begin
            if (pc_load) begin
               m_pc    <= pc_target;
               m_fault <= 1'b0;
            end
         end else if (m_have) begin
            if (pc_load) begin
               m_pc   <= pc_target;
               m_have <= 1'b0;
            end else if (pc_inc) begin
               m_pc   <= m_pc + 32'd4;
               m_have <= 1'b0;
            end
         end else begin
            if (pc_load) begin
               m_pc  <= pc_target;
               m_gap <= 1'b1;
            end else if (bad_addr(m_pc) || mem_fault) begin
               m_fault <= 1'b1;
            end else if (mem_ready) begin
               m_instr <= mem_rdata;
               m_have  <= 1'b1;
            end
         end
      end
   end

   // Compare process: outputs are a function of registered state, so sample mid-cycle.
   always @(negedge clk) begin
      logic exp_req;
      if (m_init) begin
         exp_req = !m_have && !m_fault && !m_gap && !bad_addr(m_pc);
         check("pc",          pc,                 m_pc);
         check("instruction", instruction,        m_instr);
         check("wait_instr",  32'(wait_instr),    32'(!m_have));
         check("instr_segv",  32'(instr_segv),    32'(m_fault));
         check("mem_req",     32'(mem_req),       32'(exp_req));
         if (exp_req) check("mem_addr", mem_addr, m_pc);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      reset     = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      pc_target = 32'h0;
      mem_ready = 1'b0;
      mem_fault = 1'b0;
      mem_rdata = 32'h0;
   endtask

   initial begin
      logic [31:0] prev;
      idle();
      reset = 1'b1;
      tick();
      tick();
      check("rst_pc",   pc,                 32'h0);
      check("rst_req",  32'(mem_req),       32'h0);
      check("rst_wait", 32'(wait_instr),    32'h1);
      check("rst_segv", 32'(instr_segv),    32'h0);
      check("rst_inst", instruction,        32'h0);

      // Zero-wait first fetch
      reset = 1'b0;
      tick();
      check("t1_req",  32'(mem_req), 32'h1);
      check("t1_addr", mem_addr,     32'h0);
      mem_ready = 1'b1;
      mem_rdata = 32'hC000_0001;
      tick();
      idle();
      check("t1_inst", instruction,     32'hC000_0001);
      check("t1_wait", 32'(wait_instr), 32'h0);
      check("t1_pc",   pc,              32'h0);

      // Three pc_inc with two wait states per read
      prev = 32'hC000_0001;
      for (int k = 1; k <= 3; k++) begin
         pc_inc = 1'b1;
         tick();
         pc_inc = 1'b0;
         for (int w = 0; w < 3; w++) begin
            check("t2_wait", 32'(wait_instr), 32'h1);
            check("t2_req",  32'(mem_req),    32'h1);
            check("t2_addr", mem_addr,        32'(4 * k));
            check("t2_hold", instruction,     prev);
            if (w == 2) begin
               mem_ready = 1'b1;
               mem_rdata = 32'(k * 32'h111);
            end
            tick();
            mem_ready = 1'b0;
         end
         prev = 32'(k * 32'h111);
         check("t2_inst",  instruction,     prev);
         check("t2_valid", 32'(wait_instr), 32'h0);
      end

      // Misaligned redirect faults without a request
      pc_load   = 1'b1;
      pc_target = 32'h0000_0102;
      tick();
      pc_load = 1'b0;
      check("t3_noreq", 32'(mem_req), 32'h0);
      tick();
      check("t3_segv", 32'(instr_segv), 32'h1);
      check("t3_req",  32'(mem_req),    32'h0);
      check("t3_inst", instruction,     32'h333);
      pc_inc = 1'b1;
      tick();
      pc_inc = 1'b0;
      check("t3_pcinc", pc, 32'h0000_0102);
      pc_load   = 1'b1;
      pc_target = 32'h0000_0200;
      tick();
      pc_load = 1'b0;
      check("t3_clr",  32'(instr_segv), 32'h0);
      check("t3_req2", 32'(mem_req),    32'h1);
      check("t3_addr", mem_addr,        32'h200);
      mem_ready = 1'b1;
      mem_rdata = 32'hA5A5_0200;
      tick();
      mem_ready = 1'b0;

      // Walk to the memory limit
      pc_load   = 1'b1;
      pc_target = LIMIT - 32'd4;
      tick();
      pc_load   = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 32'h0000_FFFC;
      tick();
      mem_ready = 1'b0;
      check("t4_valid", 32'(wait_instr), 32'h0);
      pc_inc = 1'b1;
      tick();
      pc_inc = 1'b0;
      check("t4_pc",    pc,           LIMIT);
      check("t4_noreq", 32'(mem_req), 32'h0);
      tick();
      check("t4_segv", 32'(instr_segv), 32'h1);
      pc_inc = 1'b1;
      tick();
      pc_inc = 1'b0;
      check("t4_hold", pc, LIMIT);

      // Fault beats ready
      pc_load   = 1'b1;
      pc_target = 32'h0000_0300;
      tick();
      pc_load   = 1'b0;
      mem_fault = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      tick();
      idle();
      check("t5_segv", 32'(instr_segv), 32'h1);
      check("t5_inst", instruction,     32'h0000_FFFC);

      // Redirect mid-fetch discards data, then reset mid-fetch
      pc_load   = 1'b1;
      pc_target = 32'h0000_0080;
      tick();
      pc_load = 1'b0;
      tick();
      pc_load   = 1'b1;
      pc_target = 32'h0000_0040;
      mem_ready = 1'b1;
      mem_rdata = 32'h0BAD_0BAD;
      tick();
      idle();
      check("t6_gap",  32'(mem_req), 32'h0);
      check("t6_pc",   pc,           32'h40);
      check("t6_inst", instruction,  32'h0000_FFFC);
      tick();
      check("t6_req",  32'(mem_req), 32'h1);
      check("t6_addr", mem_addr,     32'h40);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_rpc",   pc,              RST_PC);
      check("t6_rreq",  32'(mem_req),    32'h0);
      check("t6_rinst", instruction,     32'h0);
      check("t6_rwait", 32'(wait_instr), 32'h1);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         reset     = ($urandom_range(0, 199) == 0);
         pc_inc    = ($urandom_range(0, 2) == 0);
         pc_load   = ($urandom_range(0, 9) == 0);
         mem_ready = ($urandom_range(0, 2) == 0);
         mem_fault = ($urandom_range(0, 29) == 0);
         mem_rdata = $urandom;
         case ($urandom_range(0, 9))
            0:       pc_target = $urandom;
            1:       pc_target = ($urandom_range(0, 1) == 0) ? LIMIT - 32'd4 : LIMIT;
            default: pc_target = {16'h0, 14'($urandom), 2'b00};
         endcase
         tick();
      end
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
